// File: rtl/telem_pkg.sv
// Shared definitions for the telemetry packetizer: header bytes, packet
// lengths, FSM state type, snapshot payload and byte-selection helpers.
package telem_pkg;

    localparam logic [7:0]  TELEM_HDR0    = 8'hAA;
    localparam logic [7:0]  TELEM_HDR1    = 8'h55;
    localparam int unsigned TELEM_LEN     = 8;
    localparam int unsigned TELEM_LEN_CHK = 9;
    localparam int unsigned TELEM_IDX_W   = 3;
    localparam int unsigned TELEM_DAT_W   = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } telem_state_e;

    // Readings captured at packet start
    typedef struct packed {
        logic [TELEM_DAT_W-1:0] batt;
        logic [TELEM_DAT_W-1:0] curr;
        logic [TELEM_DAT_W-1:0] torque;
    } telem_snap_t;

    // Byte of the base packet at a given index
    function automatic logic [7:0] telem_byte(input telem_snap_t snap,
                                              input logic [TELEM_IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = TELEM_HDR0;
            3'd1:    b = TELEM_HDR1;
            3'd2:    b = {4'h0, snap.batt[11:8]};
            3'd3:    b = snap.batt[7:0];
            3'd4:    b = {4'h0, snap.curr[11:8]};
            3'd5:    b = snap.curr[7:0];
            3'd6:    b = {4'h0, snap.torque[11:8]};
            default: b = snap.torque[7:0];
        endcase
        return b;
    endfunction

    // Modulo-256 sum of the six payload bytes
    function automatic logic [7:0] telem_chksum(input telem_snap_t snap);
        logic [7:0] s;
        s = {4'h0, snap.batt[11:8]}   + snap.batt[7:0]
          + {4'h0, snap.curr[11:8]}   + snap.curr[7:0]
          + {4'h0, snap.torque[11:8]} + snap.torque[7:0];
        return s;
    endfunction

endpackage

// File: rtl/telem_period_tmr.sv
// Free-running packet period counter; tick_c is high while the count is at
// its terminal value (PERIOD-1).
//   clk    : system clock
//   rst    : synchronous active-high reset (count returns to 0)
//   tick_c : combinational terminal-count flag
module telem_period_tmr #(
    parameter int unsigned FAST_SIM = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick_c
);

    // PERIOD is a power of two, so the counter wraps naturally at all-ones
    localparam int unsigned CNT_W = (FAST_SIM != 0) ? 12 : 20;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
    end

    assign tick_c = (cnt_q == {CNT_W{1'b1}});

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/telemetry_pkt.sv
// Periodic telemetry packetizer: on each period tick (when enabled and idle)
// snapshots battery, current and torque and streams them to a UART as
// AA 55 batt_hi batt_lo curr_hi curr_lo torque_hi torque_lo, one byte per
// trmt/tx_done handshake. Defining TELEM_CHKSUM_EN appends a ninth byte,
// the modulo-256 sum of the six payload bytes.
//   clk, rst : clock, synchronous active-high reset
//   en       : allow new packets to start
//   batt, curr, torque : 12-bit readings
//   tx_done  : UART byte finished
//   trmt     : one-cycle start pulse for the UART (registered)
//   tx_data  : byte to transmit (registered, held until tx_done)
//   busy     : packet in progress (registered)
module telemetry_pkt
    import telem_pkg::*;
#(
    parameter int unsigned FAST_SIM = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [TELEM_DAT_W-1:0] batt,
    input  logic [TELEM_DAT_W-1:0] curr,
    input  logic [TELEM_DAT_W-1:0] torque,
    input  logic                   tx_done,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    output logic                   busy
);

    localparam logic [TELEM_IDX_W-1:0] IDX_LAST = TELEM_IDX_W'(TELEM_LEN - 1);

    logic                   tick_c;
    telem_state_e           state_q, state_d;
    logic [TELEM_IDX_W-1:0] idx_q, idx_d;
    telem_snap_t            snap_q, snap_d;
    logic                   trmt_q, trmt_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   busy_q, busy_d;
`ifdef TELEM_CHKSUM_EN
    logic                   chk_q, chk_d;
`endif

    telem_period_tmr #(
        .FAST_SIM (FAST_SIM)
    ) u_tmr (
        .clk    (clk),
        .rst    (rst),
        .tick_c (tick_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        trmt_d    = 1'b0;
        tx_data_d = tx_data_q;
        busy_d    = busy_q;
`ifdef TELEM_CHKSUM_EN
        chk_d     = chk_q;
`endif
        case (state_q)
            IDLE: begin
                // A tick seen outside IDLE is simply lost
                if (tick_c && en) begin
                    snap_d    = '{batt: batt, curr: curr, torque: torque};
                    idx_d     = '0;
                    trmt_d    = 1'b1;
                    tx_data_d = TELEM_HDR0;
                    busy_d    = 1'b1;
                    state_d   = SEND;
`ifdef TELEM_CHKSUM_EN
                    chk_d     = 1'b0;
`endif
                end
            end
            SEND: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
`ifdef TELEM_CHKSUM_EN
                    if (chk_q) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (idx_q == IDX_LAST) begin
                        chk_d     = 1'b1;
                        trmt_d    = 1'b1;
                        tx_data_d = telem_chksum(snap_q);
                        state_d   = SEND;
                    end else begin
                        idx_d     = idx_q + TELEM_IDX_W'(1);
                        trmt_d    = 1'b1;
                        tx_data_d = telem_byte(snap_q, idx_q + TELEM_IDX_W'(1));
                        state_d   = SEND;
                    end
`else
                    if (idx_q == IDX_LAST) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d     = idx_q + TELEM_IDX_W'(1);
                        trmt_d    = 1'b1;
                        tx_data_d = telem_byte(snap_q, idx_q + TELEM_IDX_W'(1));
                        state_d   = SEND;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            snap_q    <= '0;
            trmt_q    <= 1'b0;
            tx_data_q <= 8'h00;
            busy_q    <= 1'b0;
`ifdef TELEM_CHKSUM_EN
            chk_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            trmt_q    <= trmt_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
`ifdef TELEM_CHKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

    assign trmt    = trmt_q;
    assign tx_data = tx_data_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_telemetry_pkt.sv
// Scoreboard bench for telemetry_pkt: expected bytes are queued when a packet
// is set up and popped by a monitor on every trmt pulse.
module tb_telemetry_pkt;

`ifdef TELEM_CHKSUM_EN
    localparam int PKT_LEN = 9;
`else
    localparam int PKT_LEN = 8;
`endif
    localparam int PERIOD = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [11:0] batt = '0, curr = '0, torque = '0;
    logic        tx_done = 1'b0;
    logic        trmt, busy;
    logic [7:0]  tx_data;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          trmt_count = 0;
    bit          auto_done = 1'b1;
    int          done_delay = 10;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    telemetry_pkt #(.FAST_SIM(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .batt    (batt),
        .curr    (curr),
        .torque  (torque),
        .tx_done (tx_done),
        .trmt    (trmt),
        .tx_data (tx_data),
        .busy    (busy)
    );

    function automatic void push_pkt(input logic [11:0] b, input logic [11:0] c,
                                     input logic [11:0] t);
        logic [7:0] s;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back({4'h0, b[11:8]});
        exp_q.push_back(b[7:0]);
        exp_q.push_back({4'h0, c[11:8]});
        exp_q.push_back(c[7:0]);
        exp_q.push_back({4'h0, t[11:8]});
        exp_q.push_back(t[7:0]);
        s = {4'h0, b[11:8]} + b[7:0] + {4'h0, c[11:8]} + c[7:0]
          + {4'h0, t[11:8]} + t[7:0];
        if (PKT_LEN == 9) exp_q.push_back(s);
    endfunction

    // Monitor: every trmt pops one expected byte; pulses must be single-cycle
    initial begin : monitor
        logic [7:0] e;
        logic       prev_trmt;
        prev_trmt = 1'b0;
        forever begin
            @(negedge clk);
            if (trmt === 1'b1) begin
                trmt_count++;
                n_cmp++;
                if (prev_trmt) begin
                    n_fail++;
                    $display("FAIL trmt_width: trmt high on consecutive cycles, required single-cycle pulse");
                end else if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_trmt: got tx_data=%02h, required no trmt", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        n_fail++;
                        $display("FAIL byte: got tx_data=%02h, required %02h", tx_data, e);
                    end
                end
            end
            prev_trmt = (trmt === 1'b1);
        end
    end

    // UART model: returns tx_done done_delay cycles after each trmt
    initial begin : responder
        forever begin
            @(negedge clk);
            while (trmt === 1'b1 && auto_done) begin
                repeat (done_delay - 1) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_trmt(input int bound, output int cyc);
        cyc = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (trmt === 1'b1) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_count(input int target, input int bound, output bit ok);
        ok = (trmt_count >= target);
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            ok = (trmt_count >= target);
        end
    endtask

    task automatic test_reset();
        int cyc;
        bit ok;
        rst = 1'b1;
        en  = 1'b1;
        batt = 12'hABC; curr = 12'h123; torque = 12'h7FF;
        repeat (3) @(negedge clk);
        n_cmp++; if (trmt !== 1'b0) begin n_fail++; $display("FAIL reset_trmt: got %b, required 0", trmt); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %02h, required 00", tx_data); end
        push_pkt(12'hABC, 12'h123, 12'h7FF);
        rst = 1'b0;
        wait_trmt(5000, cyc);
        n_cmp++; if (cyc != PERIOD) begin n_fail++; $display("FAIL first_trmt_latency: got %0d cycles, required %0d", cyc, PERIOD); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %b, required 1", busy); end
        // Inputs change after the snapshot; packet must keep the old values
        @(negedge clk);
        batt = 12'h000;
        wait_idle(2000, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL pkt1_done: busy still %b, required 0", busy); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL pkt1_left: got %0d bytes pending, required 0", exp_q.size()); end
        n_cmp++; if (trmt_count != PKT_LEN) begin n_fail++; $display("FAIL pkt1_count: got %0d trmt, required %0d", trmt_count, PKT_LEN); end
    endtask

    task automatic test_stall();
        int cyc, base;
        bit ok, stable;
        logic [7:0] held;
        batt = 12'h5A5; curr = 12'h0F0; torque = 12'hC3C;
        auto_done = 1'b0;
        push_pkt(12'h5A5, 12'h0F0, 12'hC3C);
        base = trmt_count;
        wait_trmt(5000, cyc);
        n_cmp++; if (cyc < 0) begin n_fail++; $display("FAIL stall_start: got no trmt, required a packet start"); end
        held   = tx_data;
        stable = 1'b1;
        repeat (5000) begin
            @(negedge clk);
            if (tx_data !== held) stable = 1'b0;
        end
        n_cmp++; if (!stable) begin n_fail++; $display("FAIL stall_hold: got tx_data=%02h, required %02h throughout", tx_data, held); end
        n_cmp++; if (trmt_count != base + 1) begin n_fail++; $display("FAIL stall_trmt: got %0d trmt, required %0d", trmt_count - base, 1); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b, required 1", busy); end
        auto_done = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        wait_idle(2000, ok);
        n_cmp++; if (!ok || exp_q.size() != 0) begin n_fail++; $display("FAIL stall_finish: got busy=%b pending=%0d, required 0/0", busy, exp_q.size()); end
        n_cmp++; if (trmt_count != base + PKT_LEN) begin n_fail++; $display("FAIL stall_count: got %0d trmt, required %0d", trmt_count - base, PKT_LEN); end
        // The tick that fell during the stall must not start a packet now
        repeat (20) @(negedge clk);
        n_cmp++; if (trmt_count != base + PKT_LEN || busy !== 1'b0) begin n_fail++; $display("FAIL tick_dropped: got %0d trmt busy=%b, required %0d busy=0", trmt_count - base, busy, PKT_LEN); end
    endtask

    task automatic test_en_drop();
        int cyc, base;
        bit ok;
        batt = 12'h321; curr = 12'hFED; torque = 12'h800;
        push_pkt(12'h321, 12'hFED, 12'h800);
        base = trmt_count;
        wait_trmt(5000, cyc);
        n_cmp++; if (cyc < 0) begin n_fail++; $display("FAIL en_start: got no trmt, required a packet start"); end
        wait_count(base + 3, 200, ok);
        en = 1'b0;
        wait_idle(2000, ok);
        n_cmp++; if (!ok || exp_q.size() != 0) begin n_fail++; $display("FAIL en_finish: got busy=%b pending=%0d, required 0/0", busy, exp_q.size()); end
        n_cmp++; if (trmt_count != base + PKT_LEN) begin n_fail++; $display("FAIL en_count: got %0d trmt, required %0d", trmt_count - base, PKT_LEN); end
        repeat (PERIOD + 200) @(negedge clk);
        n_cmp++; if (trmt_count != base + PKT_LEN) begin n_fail++; $display("FAIL en_low_start: got %0d trmt, required %0d", trmt_count - base, PKT_LEN); end
        en = 1'b1;
    endtask

    task automatic test_rst_mid();
        int cyc, base;
        bit ok;
        batt = 12'h0C0; curr = 12'h456; torque = 12'h9AB;
        push_pkt(12'h0C0, 12'h456, 12'h9AB);
        base = trmt_count;
        wait_trmt(5000, cyc);
        n_cmp++; if (cyc < 0) begin n_fail++; $display("FAIL rst_mid_start: got no trmt, required a packet start"); end
        wait_count(base + 5, 200, ok);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (trmt !== 1'b0) begin n_fail++; $display("FAIL rst_mid_trmt: got %b, required 0", trmt); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b, required 0", busy); end
        n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_tx_data: got %02h, required 00", tx_data); end
        exp_q.delete();
        batt = 12'h111; curr = 12'h222; torque = 12'h333;
        push_pkt(12'h111, 12'h222, 12'h333);
        rst = 1'b0;
        base = trmt_count;
        wait_trmt(5000, cyc);
        n_cmp++; if (cyc != PERIOD) begin n_fail++; $display("FAIL rst_mid_latency: got %0d cycles, required %0d", cyc, PERIOD); end
        wait_idle(2000, ok);
        n_cmp++; if (!ok || exp_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_finish: got busy=%b pending=%0d, required 0/0", busy, exp_q.size()); end
        n_cmp++; if (trmt_count != base + PKT_LEN) begin n_fail++; $display("FAIL rst_mid_count: got %0d trmt, required %0d", trmt_count - base, PKT_LEN); end
    endtask

    initial begin : main
        test_reset();
        test_stall();
        test_en_drop();
        test_rst_mid();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
